imm_ext_stage: RTL and testbench

Parametrised immediate-extension pipeline stage between instruction fetch/decode and execute. It generates the sign- or zero-extended immediate for every RISC-V format (I, S, B, U, J, shamt) at XLEN 32 or 64. It also computes the PC-relative target and buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides. This decouples decode from execute stalls without a combinational ready path.

---
 rtl/imm_ext_stage_if.sv | 29 ++
 rtl/imm_ext_stage.sv | 111 +++++++++++
 tb/tb_imm_ext_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_stage_if.sv
// Handshake bundle for the immediate-extension stage: decode-side inputs,
// execute-side outputs, plus flush.
interface imm_ext_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      ImmSrc;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ImmOp;
  logic [XLEN-1:0] PCTarget;
  logic            imm_err;

  // Driver side: decode feeding the stage and execute consuming its output.
  modport master (
    output in_valid, instr, ImmSrc, pc_in, flush, out_ready,
    input  in_ready, out_valid, ImmOp, PCTarget, imm_err
  );

  // The stage itself.
  modport slave (
    input  in_valid, instr, ImmSrc, pc_in, flush, out_ready,
    output in_ready, out_valid, ImmOp, PCTarget, imm_err
  );
endinterface

// File: rtl/imm_ext_stage.sv
// RISC-V immediate extension and PC-relative target, buffered in a 2-entry
// skid buffer. in_ready comes from the registered occupancy only, so an
// execute stall never reaches decode through a combinational path.
module imm_ext_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  imm_ext_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] imm;
  } entry_t;

  logic            sgn;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic            illegal;
  entry_t          new_entry;
  entry_t          head;
  entry_t          tail;
  logic [1:0]      count;
  logic            accept;
  logic            pop;

  assign sgn = bus.instr[31];

  // Decode the immediate for the selected format. Every signed format is
  // first assembled at 32 bits and then sign-extended to XLEN.
  always_comb begin
    imm32   = '0;
    imm_x   = '0;
    illegal = 1'b0;
    case (bus.ImmSrc)
      3'b000: imm32 = {{20{sgn}}, bus.instr[31:20]};
      3'b001: imm32 = {{20{sgn}}, bus.instr[31:25], bus.instr[11:7]};
      3'b010: imm32 = {{19{sgn}}, bus.instr[31], bus.instr[7],
                       bus.instr[30:25], bus.instr[11:8], 1'b0};
      3'b011: imm32 = {bus.instr[31:12], 12'b0};
      3'b100: imm32 = {{11{sgn}}, bus.instr[31], bus.instr[19:12],
                       bus.instr[20], bus.instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_x = XLEN'($signed(imm32));
    if (bus.ImmSrc == 3'b101) begin
      imm_x = XLEN'(bus.instr[20 +: SH_W]);
    end else if (bus.ImmSrc[2:1] == 2'b11) begin
      imm_x   = '0;
      illegal = 1'b1;
    end
  end

  assign new_entry.imm = imm_x;
  assign new_entry.tgt = bus.pc_in + imm_x;
  assign new_entry.err = illegal;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.ImmOp     = head.imm;
  assign bus.PCTarget  = head.tgt;
  assign bus.imm_err   = head.err;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // Occupancy: flush wins over any same-cycle accept or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (bus.flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0:    if (accept) count <= 2'd1;
        2'd1:    if (accept && !pop) count <= 2'd2;
                 else if (!accept && pop) count <= 2'd0;
        2'd2:    if (pop) count <= 2'd1;
        default: count <= 2'd0;
      endcase
    end
  end

  // Entry storage: head drives the outputs and is left untouched when the
  // buffer empties, so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!bus.flush) begin
      case (count)
        2'd0: if (accept) head <= new_entry;
        2'd1: begin
          if (accept && pop) head <= new_entry;
          else if (accept)   tail <= new_entry;
        end
        2'd2: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared each cycle against a queue-based reference model
// that computes immediates arithmetically from the instruction fields.
module tb_imm_ext_stage;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc;
    bit          zero;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  src = '0;
  logic [63:0] pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  ent_t shown;

  imm_ext_stage_if #(.XLEN(32)) bus32 ();
  imm_ext_stage_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.instr     = instr;
  assign bus32.ImmSrc    = src;
  assign bus32.pc_in     = pc[31:0];
  assign bus32.flush     = flush;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.instr     = instr;
  assign bus64.ImmSrc    = src;
  assign bus64.pc_in     = pc;
  assign bus64.flush     = flush;
  assign bus64.out_ready = out_ready;

  imm_ext_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  imm_ext_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  always #5 clk = ~clk;

  function automatic void ref_ext(input ent_t e, input int xlen,
                                  output logic [63:0] imm, output logic [63:0] tgt,
                                  output logic err);
    longint v;
    logic [63:0] mask;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v    = 0;
    err  = 1'b0;
    if (e.zero) begin
      imm = '0;
      tgt = '0;
      return;
    end
    case (e.src)
      3'd0: v = longint'(e.instr[31:20]) - (e.instr[31] ? 64'sd4096 : 64'sd0);
      3'd1: v = longint'(e.instr[31:25]) * 32 + longint'(e.instr[11:7])
                - (e.instr[31] ? 64'sd4096 : 64'sd0);
      3'd2: v = longint'(e.instr[7]) * 2048 + longint'(e.instr[30:25]) * 32
                + longint'(e.instr[11:8]) * 2 - (e.instr[31] ? 64'sd4096 : 64'sd0);
      3'd3: v = longint'(e.instr[31:12]) * 4096
                - (e.instr[31] ? 64'sd4294967296 : 64'sd0);
      3'd4: v = longint'(e.instr[19:12]) * 4096 + longint'(e.instr[20]) * 2048
                + longint'(e.instr[30:21]) * 2 - (e.instr[31] ? 64'sd1048576 : 64'sd0);
      3'd5: v = (xlen == 64) ? longint'(e.instr[25:20]) : longint'(e.instr[24:20]);
      default: begin
        v   = 0;
        err = 1'b1;
      end
    endcase
    imm = 64'(v) & mask;
    tgt = (e.pc + 64'(v)) & mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    ent_t h;
    logic [63:0] ei, et;
    logic ee;
    h = (q.size() != 0) ? q[0] : shown;
    chk("out_valid32", 64'(bus32.out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(bus64.out_valid), 64'(q.size() != 0));
    ref_ext(h, 32, ei, et, ee);
    chk("imm32", 64'(bus32.ImmOp), ei);
    chk("tgt32", 64'(bus32.PCTarget), et);
    chk("err32", 64'(bus32.imm_err), 64'(ee));
    ref_ext(h, 64, ei, et, ee);
    chk("imm64", bus64.ImmOp, ei);
    chk("tgt64", bus64.PCTarget, et);
    chk("err64", 64'(bus64.imm_err), 64'(ee));
  endtask

  // One clock: check in_ready, predict the handshake, advance the model.
  task automatic cyc();
    ent_t cur;
    bit acc, pp;
    chk("in_ready32", 64'(bus32.in_ready), 64'(q.size() != 2));
    chk("in_ready64", 64'(bus64.in_ready), 64'(q.size() != 2));
    cur.instr = instr;
    cur.src   = src;
    cur.pc    = pc;
    cur.zero  = 1'b0;
    acc = in_valid && (q.size() != 2);
    pp  = out_ready && (q.size() != 0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    if (q.size() != 0) shown = q[0];
    #1;
    check_outs();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                       input logic [63:0] p);
    in_valid = v;
    instr    = i;
    src      = s;
    pc       = p;
  endtask

  initial begin
    bit acc_c;
    shown.instr = '0;
    shown.src   = '0;
    shown.pc    = '0;
    shown.zero  = 1'b1;

    // Reset state
    #1;
    check_outs();
    chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // I and B formats at XLEN=32
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'b000, 64'h100);
    cyc();
    chk("I_imm", 64'(bus32.ImmOp), 64'hFFFF_FFFF);
    chk("I_tgt", 64'(bus32.PCTarget), 64'h0000_00FF);
    chk("I_err", 64'(bus32.imm_err), 64'd0);
    drive(1'b1, 32'hFE000EE3, 3'b010, 64'h200);
    cyc();
    chk("B_imm", 64'(bus32.ImmOp), 64'hFFFF_FFFC);
    chk("B_tgt", 64'(bus32.PCTarget), 64'h0000_01FC);

    // U, J, illegal back-to-back
    drive(1'b1, 32'h12345037, 3'b011, 64'h300);
    cyc();
    chk("U_imm", 64'(bus32.ImmOp), 64'h1234_5000);
    drive(1'b1, 32'h0080006F, 3'b100, 64'h400);
    cyc();
    chk("J_imm", 64'(bus32.ImmOp), 64'h0000_0008);
    drive(1'b1, 32'hDEADBEEF, 3'b110, 64'h500);
    cyc();
    chk("ILL_imm", 64'(bus32.ImmOp), 64'd0);
    chk("ILL_err", 64'(bus32.imm_err), 64'd1);
    chk("ILL_tgt", 64'(bus32.PCTarget), 64'h500);

    // XLEN=64 vectors
    drive(1'b1, 32'hFE002C23, 3'b001, 64'h1000);
    cyc();
    chk("S64_imm", bus64.ImmOp, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(1'b1, 32'h80000037, 3'b011, 64'h1000);
    cyc();
    chk("U64_imm", bus64.ImmOp, 64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h03F01013, 3'b101, 64'h1000);
    cyc();
    chk("SH64_imm", bus64.ImmOp, 64'h3F);
    chk("SH32_imm", 64'(bus32.ImmOp), 64'h1F);
    drive(1'b0, 32'h0, 3'b000, 64'h0);
    cyc();

    // Backpressure: A, B accepted, C held until space frees
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'b000, 64'h10);
    cyc();
    drive(1'b1, 32'h00200093, 3'b000, 64'h20);
    cyc();
    chk("bp_in_ready", 64'(bus32.in_ready), 64'd0);
    drive(1'b1, 32'h00300093, 3'b000, 64'h30);
    cyc();
    cyc();
    chk("bp_head_A", 64'(bus32.PCTarget), 64'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acc_c = in_valid && (q.size() != 2);
      cyc();
      if (acc_c) in_valid = 1'b0;
    end
    chk("bp_drained", 64'(bus32.out_valid), 64'd0);
    chk("bp_last_C", 64'(bus32.PCTarget), 64'h33);

    // Flush with the buffer full and a pending input
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 3'b000, 64'h40);
    cyc();
    drive(1'b1, 32'h00500093, 3'b000, 64'h50);
    cyc();
    drive(1'b1, 32'h00600093, 3'b000, 64'h60);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus32.in_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
            {$urandom, $urandom});
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0;

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    drive(1'b1, 32'h00700093, 3'b000, 64'h70);
    cyc();
    cyc();
    cyc();
    chk("rs_full", 64'(bus32.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    q.delete();
    shown.zero = 1'b1;
    #1;
    check_outs();
    chk("rs_in_ready", 64'(bus64.in_ready), 64'd1);
    chk("rs_imm64", bus64.ImmOp, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 32'h80000037, 3'b011, 64'h80);
    cyc();
    chk("rs_first", 64'(bus32.out_valid), 64'd1);
    chk("rs_first_imm", 64'(bus32.ImmOp), 64'h8000_0000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
